// File: rtl/seq_detector.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector
// Description : Serial pattern detector with overlapping detection, a
//               saturating match counter and a sticky overflow flag.
//               Bits are accepted on rising clk edges where enable=1; each
//               accepted bit shifts into a PAT_LEN-bit history at bit 0.
//               A match is declared when the history is fully populated and
//               equals pattern (pattern[PAT_LEN-1] oldest, pattern[0] newest).
// Ports       :
//   clk       in   1        clock, rising edge
//   reset     in   1        asynchronous active-low reset
//   din       in   1        serial data bit
//   enable    in   1        din qualifier
//   pattern   in   PAT_LEN  target sequence
//   clear     in   1        synchronous clear of count/overflow
//   match     out  1        registered one-cycle match pulse
//   count     out  CNT_W    saturating number of matches
//   overflow  out  1        sticky saturation flag
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    input  logic               enable,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               clear,
    output logic               match,
    output logic [CNT_W-1:0]   count,
    output logic               overflow
);

    localparam int             c_FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [c_FILL_W-1:0] c_FILL_ONE  = c_FILL_W'(1);
    localparam logic [c_FILL_W-1:0] c_FILL_LAST = c_FILL_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    c_CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } fill_state_t;

    fill_state_t         state_q, state_d;
    logic [c_FILL_W-1:0] fill_q,  fill_d;
    logic [PAT_LEN-1:0]  hist_q,  hist_d;
    logic                match_q, match_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ovf_q,   ovf_d;
    logic                hit;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            fill_q  <= '0;
            hist_q  <= '0;
            match_q <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            hist_q  <= hist_d;
            match_q <= match_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        hist_d  = hist_q;
        hit     = 1'b0;
        count_d = count_q;
        ovf_d   = ovf_q;

        // din is only looked at when enable=1, so an X on an idle cycle
        // never reaches the history register.
        if (enable) begin
            hist_d = {hist_q[PAT_LEN-2:0], din};
            if (state_q != FULL) begin
                fill_d = fill_q + c_FILL_ONE;
            end
        end

        case (state_q)
            EMPTY: begin
                if (enable) begin
                    state_d = FILLING;
                end
            end
            FILLING: begin
                if (enable && (fill_q == c_FILL_LAST)) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                state_d = FULL;
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Compare against the updated history so the pulse follows the very
        // edge that accepted the completing bit. History is never flushed,
        // which makes detection overlapping.
        hit = enable && (state_d == FULL) && (hist_d == pattern);

        // A match in the same cycle as clear wins over the clear: the
        // counter restarts at 1 rather than 0.
        if (hit) begin
            if (clear) begin
                count_d = c_CNT_ONE;
                ovf_d   = 1'b0;
            end else if (count_q == c_CNT_MAX) begin
                ovf_d   = 1'b1;
            end else begin
                count_d = count_q + c_CNT_ONE;
            end
        end else if (clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    assign match_d  = hit;
    assign match    = match_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detector
// Description : Self-checking bench for seq_detector. Two instances share
//               the serial stream: A (PAT_LEN=4, CNT_W=8) and B (PAT_LEN=2,
//               CNT_W=2). A reference model keeps the list of bits accepted
//               since reset and matches the last PAT_LEN of them against the
//               pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector;

    logic       clk;
    logic       reset;
    logic       din;
    logic       enable;
    logic       clear;
    logic [3:0] pat_a;
    logic [1:0] pat_b;

    logic       match_a, ovf_a;
    logic [7:0] count_a;
    logic       match_b, ovf_b;
    logic [1:0] count_b;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit  acc[$];
    int  exp_cnt[2];
    bit  exp_ovf[2];
    bit  exp_m[2];

    seq_detector #(.PAT_LEN(4), .CNT_W(8)) u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .enable   (enable),
        .pattern  (pat_a),
        .clear    (clear),
        .match    (match_a),
        .count    (count_a),
        .overflow (ovf_a)
    );

    seq_detector #(.PAT_LEN(2), .CNT_W(2)) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .enable   (enable),
        .pattern  (pat_b),
        .clear    (clear),
        .match    (match_b),
        .count    (count_b),
        .overflow (ovf_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        acc.delete();
        for (int k = 0; k < 2; k++) begin
            exp_cnt[k] = 0;
            exp_ovf[k] = 1'b0;
            exp_m[k]   = 1'b0;
        end
    endtask

    // One rising edge as seen from the requirements.
    task automatic model_edge();
        int len;
        int maxc;
        logic [3:0] p;
        bit m;
        if (enable) acc.push_back(din);
        for (int k = 0; k < 2; k++) begin
            len  = (k == 0) ? 4 : 2;
            maxc = (k == 0) ? 255 : 3;
            p    = (k == 0) ? pat_a : {2'b00, pat_b};
            m    = 1'b0;
            if (enable && acc.size() >= len) begin
                m = 1'b1;
                for (int i = 0; i < len; i++) begin
                    if (acc[acc.size() - 1 - i] != p[i]) m = 1'b0;
                end
            end
            exp_m[k] = m;
            if (m) begin
                if (clear) begin
                    exp_cnt[k] = 1;
                    exp_ovf[k] = 1'b0;
                end else if (exp_cnt[k] == maxc) begin
                    exp_ovf[k] = 1'b1;
                end else begin
                    exp_cnt[k] = exp_cnt[k] + 1;
                end
            end else if (clear) begin
                exp_cnt[k] = 0;
                exp_ovf[k] = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, "_match_a"}, 32'(match_a), 32'(exp_m[0]));
        chk({ph, "_count_a"}, 32'(count_a), 32'(exp_cnt[0]));
        chk({ph, "_ovf_a"},   32'(ovf_a),   32'(exp_ovf[0]));
        chk({ph, "_match_b"}, 32'(match_b), 32'(exp_m[1]));
        chk({ph, "_count_b"}, 32'(count_b), 32'(exp_cnt[1]));
        chk({ph, "_ovf_b"},   32'(ovf_b),   32'(exp_ovf[1]));
    endtask

    // Inputs are changed 1 time unit after a rising edge, so they are stable
    // when the model reads them at the next edge.
    task automatic tick(input logic e, input logic d, input logic c);
        enable = e;
        din    = e ? d : 1'bx;
        clear  = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all("edge");
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        model_reset();
        check_all("rst");
        reset = 1'b1;
    endtask

    initial begin
        reset  = 1'b1;
        din    = 1'b0;
        enable = 1'b0;
        clear  = 1'b0;
        pat_a  = 4'b1011;
        pat_b  = 2'b11;
        model_reset();
        #1;
        do_reset();

        // basic match 1011
        tick(1, 1, 0); tick(1, 0, 0); tick(1, 1, 0); tick(1, 1, 0);
        chk("basic_match", 32'(match_a), 32'd1);
        chk("basic_count", 32'(count_a), 32'd1);
        tick(0, 0, 0);
        chk("basic_pulse_end", 32'(match_a), 32'd0);

        // overlap 1,0,1,1,0,1,1
        do_reset();
        tick(1, 1, 0); tick(1, 0, 0); tick(1, 1, 0); tick(1, 1, 0);
        tick(1, 0, 0); tick(1, 1, 0); tick(1, 1, 0);
        chk("overlap_match", 32'(match_a), 32'd1);
        chk("overlap_count", 32'(count_a), 32'd2);

        // enable gap with X on din
        do_reset();
        tick(1, 1, 0); tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
        tick(1, 1, 0); tick(1, 1, 0);
        chk("gap_count", 32'(count_a), 32'd1);

        // all-zero pattern must not match on the reset-zero history
        pat_a = 4'b0000;
        do_reset();
        tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0);
        chk("zero_pat_count", 32'(count_a), 32'd0);
        tick(1, 0, 0);
        chk("zero_pat_4th", 32'(count_a), 32'd1);

        // reset mid-stream discards partial history
        pat_a = 4'b1011;
        do_reset();
        tick(1, 1, 0); tick(1, 0, 0); tick(1, 1, 0);
        do_reset();
        tick(1, 1, 0);
        chk("midrst_nomatch", 32'(match_a), 32'd0);
        tick(1, 1, 0); tick(1, 0, 0); tick(1, 1, 0); tick(1, 1, 0);
        chk("midrst_count", 32'(count_a), 32'd1);

        // saturation on B (pattern 11, CNT_W=2) and count=5 on A (1111)
        pat_a = 4'b1111;
        pat_b = 2'b11;
        do_reset();
        for (int i = 0; i < 5; i++) tick(1, 1, 0);
        chk("sat_b_cnt4", 32'(count_b), 32'd3);
        chk("sat_b_ovf4", 32'(ovf_b), 32'd1);
        tick(1, 1, 0);
        chk("sat_b_cnt5", 32'(count_b), 32'd3);
        chk("sat_b_ovf5", 32'(ovf_b), 32'd1);
        tick(1, 1, 0); tick(1, 1, 0);
        chk("coll_pre_count", 32'(count_a), 32'd5);
        // clear on the same edge as a match
        tick(1, 1, 1);
        chk("coll_match", 32'(match_a), 32'd1);
        chk("coll_count", 32'(count_a), 32'd1);
        chk("coll_ovf_b", 32'(ovf_b), 32'd0);
        // clear without match
        tick(0, 0, 1);
        chk("clear_count", 32'(count_a), 32'd0);
        // clear must not disturb history: next 1 still matches
        tick(1, 1, 0);
        chk("clear_hist_kept", 32'(match_a), 32'd1);

        // randomized stream
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            if ($urandom_range(0, 39) == 0) pat_a = 4'($urandom);
            if ($urandom_range(0, 39) == 0) pat_b = 2'($urandom);
            tick(($urandom_range(0, 3) != 0), 1'($urandom),
                 ($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
